multi_phase_intersection: RTL and testbench

MULTI_PHASE_INTERSECTION -- requirements
Module: multi_phase_intersection

---
 rtl/intersection_pkg.sv | 26 ++
 rtl/phase_timer.sv | 36 +++
 rtl/multi_phase_intersection.sv | 172 +++++++++++++++++
 tb/tb_multi_phase_intersection.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared constants for the multi-phase intersection controller: FSM state
// encoding, per-phase lamp masks {red, ylw, grn} and timer sizing helpers.
package intersection_pkg;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_GRN    = 3'd1;
    localparam logic [2:0] ST_YLW    = 3'd2;
    localparam logic [2:0] ST_ALLRED = 3'd3;
    localparam logic [2:0] ST_FLASH  = 3'd4;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YLW = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_ERR = 3'b111;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold max_val; never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by every controller state; it idles at zero
// and reports zero so the FSM can end the current interval.
module phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        if (load) begin
            count_d = load_val;
        end else if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/multi_phase_intersection.sv
// Round-robin traffic signal controller with sticky pedestrian requests that
// extend a phase's green, a maintenance yellow-flash mode and an all-red restart.
module multi_phase_intersection
    import intersection_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int GRN_TON    = 20,
    parameter int YLW_TON    = 3,
    parameter int RED_TON    = 2,
    parameter int EXT_TON    = 10,
    parameter int FLASH_HALF = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PHASES-1:0]         crosswalk,
    input  logic                          flash,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         ylw,
    output logic [NUM_PHASES-1:0]         grn,
    output logic [NUM_PHASES-1:0]         walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          busy_flash
);

    localparam int PW   = $clog2(NUM_PHASES);
    localparam int TMAX = max_of(max_of(GRN_TON + EXT_TON, YLW_TON), max_of(RED_TON, FLASH_HALF)) - 1;
    localparam int TW   = width_for(TMAX);

    logic [2:0]            state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [NUM_PHASES-1:0] req_q, req_d;
    logic                  tog_q, tog_d;
    logic                  ext_q, ext_d;
    logic                  restart_q, restart_d;
    logic                  load_s;
    logic [TW-1:0]         load_val_s;
    logic                  zero_s;
    logic                  enter_grn_s;
    logic [NUM_PHASES-1:0] clr_s;
    logic [PW-1:0]         next_phase_s;
    logic [2:0]            lamp_s;

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (reset_n),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    assign next_phase_s = (phase_q == PW'(NUM_PHASES - 1)) ? {PW{1'b0}} : phase_q + PW'(1);

    // Next-state, phase and timer-load decision; flash preempts every running state.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tog_d       = tog_q;
        ext_d       = ext_q;
        restart_d   = restart_q;
        load_s      = 1'b0;
        load_val_s  = {TW{1'b0}};
        enter_grn_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d     = ST_GRN;
                phase_d     = {PW{1'b0}};
                enter_grn_s = 1'b1;
            end
            ST_GRN, ST_YLW, ST_ALLRED: begin
                if (flash) begin
                    state_d    = ST_FLASH;
                    tog_d      = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = TW'(FLASH_HALF - 1);
                end else if (!zero_s) begin
                    state_d = state_q;
                end else if (state_q == ST_GRN) begin
                    state_d    = ST_YLW;
                    load_s     = 1'b1;
                    load_val_s = TW'(YLW_TON - 1);
                end else if (state_q == ST_YLW) begin
                    state_d    = ST_ALLRED;
                    load_s     = 1'b1;
                    load_val_s = TW'(RED_TON - 1);
                end else begin
                    state_d     = ST_GRN;
                    phase_d     = restart_q ? {PW{1'b0}} : next_phase_s;
                    enter_grn_s = 1'b1;
                end
            end
            ST_FLASH: begin
                if (!flash) begin
                    state_d    = ST_ALLRED;
                    phase_d    = {PW{1'b0}};
                    restart_d  = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = TW'(RED_TON - 1);
                end else if (zero_s) begin
                    tog_d      = ~tog_q;
                    load_s     = 1'b1;
                    load_val_s = TW'(FLASH_HALF - 1);
                end else begin
                    tog_d = tog_q;
                end
            end
            default: begin
                state_d    = ST_ALLRED;
                phase_d    = {PW{1'b0}};
                restart_d  = 1'b1;
                load_s     = 1'b1;
                load_val_s = TW'(RED_TON - 1);
            end
        endcase
        // Extension is decided once, from requests visible on the entry edge.
        if (enter_grn_s) begin
            ext_d      = req_q[phase_d] | crosswalk[phase_d];
            restart_d  = 1'b0;
            load_s     = 1'b1;
            load_val_s = ext_d ? TW'(GRN_TON + EXT_TON - 1) : TW'(GRN_TON - 1);
            clr_s      = NUM_PHASES'(1) << phase_d;
        end else begin
            clr_s      = {NUM_PHASES{1'b0}};
        end
        req_d = (req_q | crosswalk) & ~clr_s;
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= ST_INIT;
            phase_q   <= {PW{1'b0}};
            req_q     <= {NUM_PHASES{1'b0}};
            tog_q     <= 1'b0;
            ext_q     <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            req_q     <= req_d;
            tog_q     <= tog_d;
            ext_q     <= ext_d;
            restart_q <= restart_d;
        end
    end

    // Per-phase lamp decode from registered state.
    always_comb begin
        red    = {NUM_PHASES{1'b0}};
        ylw    = {NUM_PHASES{1'b0}};
        grn    = {NUM_PHASES{1'b0}};
        walk   = {NUM_PHASES{1'b0}};
        lamp_s = LAMP_OFF;
        for (int i = 0; i < NUM_PHASES; i++) begin
            case (state_q)
                ST_INIT:   lamp_s = LAMP_OFF;
                ST_GRN:    lamp_s = (PW'(i) == phase_q) ? LAMP_GRN : LAMP_RED;
                ST_YLW:    lamp_s = (PW'(i) == phase_q) ? LAMP_YLW : LAMP_RED;
                ST_ALLRED: lamp_s = LAMP_RED;
                ST_FLASH:  lamp_s = tog_q ? LAMP_YLW : LAMP_OFF;
                default:   lamp_s = LAMP_ERR;
            endcase
            red[i]  = lamp_s[2];
            ylw[i]  = lamp_s[1];
            grn[i]  = lamp_s[0];
            walk[i] = (state_q == ST_GRN) && (PW'(i) == phase_q) && ext_q;
        end
    end

    assign phase      = phase_q;
    assign busy_flash = (state_q == ST_FLASH);

endmodule

// File: tb/tb_multi_phase_intersection.sv
// Directed scenarios plus randomized traffic, compared every cycle against an
// interval-based reference model of the intersection.
module tb_multi_phase_intersection;

    localparam int N          = 3;
    localparam int GRN        = 5;
    localparam int YLW        = 2;
    localparam int RED        = 1;
    localparam int EXT        = 4;
    localparam int FLASH_HALF = 3;

    localparam int M_INIT = 0, M_GREEN = 1, M_YELLOW = 2, M_CLEAR = 3, M_FLASHING = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] crosswalk;
    logic         flash;
    logic [N-1:0] red, ylw, grn, walk;
    logic [1:0]   phase;
    logic         busy_flash;

    int n_vec = 0;
    int n_err = 0;

    int         m_mode, m_phase, m_left;
    bit         m_ext, m_on, m_home;
    bit [N-1:0] m_req;

    multi_phase_intersection #(
        .NUM_PHASES (N),
        .GRN_TON    (GRN),
        .YLW_TON    (YLW),
        .RED_TON    (RED),
        .EXT_TON    (EXT),
        .FLASH_HALF (FLASH_HALF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .crosswalk  (crosswalk),
        .flash      (flash),
        .red        (red),
        .ylw        (ylw),
        .grn        (grn),
        .walk       (walk),
        .phase      (phase),
        .busy_flash (busy_flash)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT; m_phase = 0; m_left = 0;
        m_ext = 1'b0; m_on = 1'b0; m_home = 1'b0; m_req = '0;
    endtask

    task automatic model_begin_green(input int p, input bit [N-1:0] pend);
        m_mode   = M_GREEN;
        m_phase  = p;
        m_ext    = pend[p];
        m_left   = GRN + (m_ext ? EXT : 0);
        m_home   = 1'b0;
        m_req[p] = 1'b0;
    endtask

    // m_left counts the cycles remaining in the current interval, this one included.
    task automatic model_step();
        bit [N-1:0] pend;
        pend  = m_req | crosswalk;
        m_req = pend;
        case (m_mode)
            M_INIT: model_begin_green(0, pend);
            M_FLASHING: begin
                if (!flash) begin
                    m_mode = M_CLEAR; m_left = RED; m_phase = 0; m_home = 1'b1;
                end else if (m_left == 1) begin
                    m_on = !m_on; m_left = FLASH_HALF;
                end else begin
                    m_left--;
                end
            end
            default: begin
                if (flash) begin
                    m_mode = M_FLASHING; m_on = 1'b1; m_left = FLASH_HALF;
                end else if (m_left > 1) begin
                    m_left--;
                end else if (m_mode == M_GREEN) begin
                    m_mode = M_YELLOW; m_left = YLW;
                end else if (m_mode == M_YELLOW) begin
                    m_mode = M_CLEAR; m_left = RED;
                end else begin
                    model_begin_green(m_home ? 0 : (m_phase + 1) % N, pend);
                end
            end
        endcase
    endtask

    function automatic logic [31:0] exp_lamps();
        logic [N-1:0] r, y, g, w;
        r = '0; y = '0; g = '0; w = '0;
        for (int i = 0; i < N; i++) begin
            if (m_mode == M_GREEN || m_mode == M_YELLOW) begin
                if (i == m_phase) begin
                    g[i] = (m_mode == M_GREEN);
                    y[i] = (m_mode == M_YELLOW);
                    w[i] = (m_mode == M_GREEN) && m_ext;
                end else begin
                    r[i] = 1'b1;
                end
            end else if (m_mode == M_CLEAR) begin
                r[i] = 1'b1;
            end else if (m_mode == M_FLASHING) begin
                y[i] = m_on;
            end
        end
        return {20'd0, r, y, g, w};
    endfunction

    task automatic compare_all();
        check_val("lamps", {20'd0, red, ylw, grn, walk}, exp_lamps());
        check_val("phase", {30'd0, phase}, m_phase);
        check_val("busy_flash", {31'd0, busy_flash}, {31'd0, m_mode == M_FLASHING});
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse in mid-cycle; released on the falling edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b1;
        #1;
        model_reset();
        check_val("reset_lamps", {20'd0, red, ylw, grn, walk}, 32'd0);
        check_val("reset_phase", {30'd0, phase}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    task automatic wait_lamp(input bit use_ylw, input logic [N-1:0] pat);
        int k;
        for (k = 0; k < 100; k++) begin
            if ((use_ylw ? ylw : grn) == pat) break;
            step();
        end
        if (k == 100) check_val("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic measure_green(input int p, output int len);
        logic [N-1:0] pat;
        pat = '0;
        pat[p] = 1'b1;
        wait_lamp(1'b0, pat);
        len = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (grn[p]) len++;
            else break;
        end
    endtask

    initial begin
        int cnt_g0, cnt_y0, cnt_ar, cnt_g1, cnt_w1, len;
        clk = 1'b0; reset_n = 1'b1; crosswalk = '0; flash = 1'b0;
        model_reset();
        #12;
        compare_all();
        check_val("reset_zero", {20'd0, red, ylw, grn, walk, phase, busy_flash}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;

        // Unloaded cycle: 3 x (5 + 2 + 1) = 24 cycles before phase 0 returns.
        cnt_g0 = 0; cnt_y0 = 0; cnt_ar = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (grn == 3'b001) cnt_g0++;
            if (ylw == 3'b001) cnt_y0++;
            if (red == 3'b111 && ylw == 3'b000 && grn == 3'b000) cnt_ar++;
        end
        check_val("grn0_cycles", cnt_g0, 32'd5);
        check_val("ylw0_cycles", cnt_y0, 32'd2);
        check_val("allred_cycles", cnt_ar, 32'd3);
        step();
        check_val("wrap_to_grn0", {29'd0, grn}, 32'd1);

        // Crosswalk 1 pulse during phase-0 green.
        crosswalk = 3'b010;
        step();
        crosswalk = '0;
        cnt_g1 = 0; cnt_w1 = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (grn == 3'b010) cnt_g1++;
            if (walk == 3'b010) cnt_w1++;
        end
        check_val("grn1_extended", cnt_g1, 32'd9);
        check_val("walk1_cycles", cnt_w1, 32'd9);

        // Own-phase request mid-green does not extend the running green.
        wait_lamp(1'b0, 3'b001);
        len = 1;
        step(); len++;
        crosswalk = 3'b001;
        step(); len++;
        crosswalk = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (grn[0]) len++;
            else break;
        end
        check_val("grn0_not_extended", len, 32'd5);
        measure_green(0, len);
        check_val("grn0_next_extended", len, 32'd9);

        // Crosswalk 2 held across the phase-2 entry edge and through its green.
        wait_lamp(1'b1, 3'b010);
        crosswalk = 3'b100;
        measure_green(2, len);
        crosswalk = '0;
        check_val("grn2_held_extended", len, 32'd9);
        measure_green(2, len);
        check_val("grn2_requeued", len, 32'd9);

        // Flash requested during phase-2 yellow.
        wait_lamp(1'b1, 3'b100);
        flash = 1'b1;
        step();
        check_val("flash_on1", {29'd0, ylw}, 32'd7);
        check_val("flash_busy", {31'd0, busy_flash}, 32'd1);
        for (int k = 2; k <= 7; k++) begin
            step();
            if (k == 4) check_val("flash_off", {29'd0, ylw}, 32'd0);
            if (k == 7) check_val("flash_on2", {29'd0, ylw}, 32'd7);
        end
        flash = 1'b0;
        step();
        check_val("flash_exit_allred", {26'd0, red, grn}, {26'd0, 3'b111, 3'b000});
        step();
        check_val("flash_exit_grn0", {29'd0, grn}, 32'd1);

        // Reset in the middle of phase-1 green.
        wait_lamp(1'b0, 3'b010);
        step();
        step();
        do_reset();
        step();
        check_val("post_reset_grn0", {29'd0, grn}, 32'd1);

        // Randomized traffic with bursty flash and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            crosswalk = '0;
            for (int i = 0; i < N; i++) crosswalk[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) flash = ~flash;
            if ($urandom_range(0, 799) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
